// File: rtl/button_msg_tx.sv
// Button message transmitter: turns button press pulses into "BTNx\r\n" byte
// streams on a valid/ready UART byte interface, with an idle gap after each message.
module button_msg_tx #(
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] press,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam bit          GAP_EN   = (GAP_CYCLES != 0);
    localparam logic [15:0] GAP_LOAD = GAP_EN ? 16'(GAP_CYCLES - 1) : 16'd0;

    logic [1:0]  state_q, state_d;
    logic [1:0]  pending_q, pending_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        last_q, last_d;
    logic        overflow_q, overflow_d;

    logic        start;
    logic        sel_next;
    logic [1:0]  clear;
    logic [7:0]  msg_byte;

    // A press landing on the cycle its flag is consumed simply re-arms it.
    always_comb begin
        start     = (state_q == ST_IDLE) && (pending_q != 2'b00);
        sel_next  = (pending_q == 2'b11) ? ~last_q : pending_q[1];
        clear     = start ? (sel_next ? 2'b10 : 2'b01) : 2'b00;
        pending_d  = press | (pending_q & ~clear);
        overflow_d = |(press & pending_q & ~clear);
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    last_d     = sel_next;
                    byte_idx_d = 3'd0;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (byte_idx_q == 3'd5) begin
                        byte_idx_d = 3'd0;
                        if (GAP_EN) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // During SEND, last_q names the button whose message is on the wire.
    always_comb begin
        case (byte_idx_q)
            3'd0:    msg_byte = 8'h42;
            3'd1:    msg_byte = 8'h54;
            3'd2:    msg_byte = 8'h4E;
            3'd3:    msg_byte = last_q ? 8'h31 : 8'h30;
            3'd4:    msg_byte = 8'h0D;
            3'd5:    msg_byte = 8'h0A;
            default: msg_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 2'b00;
            byte_idx_q <= 3'd0;
            gap_cnt_q  <= 16'd0;
            last_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_valid = (state_q == ST_SEND);
    assign tx_data  = tx_valid ? msg_byte : 8'h00;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_button_msg_tx.sv
// Directed testbench for button_msg_tx: one instance with a 4-cycle gap and one
// with no gap, sharing the same stimulus; each task checks its own scenario.
module tb_button_msg_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] press;
    logic       tx_ready;
    logic [7:0] tx_data, tx_data0;
    logic       tx_valid, tx_valid0;
    logic       busy, busy0;
    logic       overflow, overflow0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_msg_tx #(.GAP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .press(press), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overflow(overflow)
    );

    button_msg_tx #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .press(press), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0), .overflow(overflow0)
    );

    function automatic logic [7:0] msg_byte(input logic btn, input int idx);
        case (idx)
            0:       return 8'h42;
            1:       return 8'h54;
            2:       return 8'h4E;
            3:       return btn ? 8'h31 : 8'h30;
            4:       return 8'h0D;
            5:       return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        press    = 2'b00;
        tx_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        press    = 2'b11;
        tx_ready = 1'b1;
        step();
        rst_n = 1'b1;
        press = 2'b00;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", tx_valid); end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h exp=00", tx_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || tx_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_press_ignored cyc=%0d busy=%b valid=%b exp=0/0", i, busy, tx_valid);
            end
        end
    endtask

    task automatic test_single();
        logic       ev, eb;
        logic [7:0] ed;
        do_reset();
        tx_ready = 1'b1;
        press    = 2'b01;
        for (int off = 1; off <= 13; off++) begin
            step();
            press = 2'b00;
            ev = (off >= 2 && off <= 7);
            ed = ev ? msg_byte(1'b0, off - 2) : 8'h00;
            eb = (off >= 2 && off <= 11);
            checks++;
            if (tx_valid !== ev || tx_data !== ed || busy !== eb) begin
                errors++;
                $display("[TB] FAIL single off=%0d got v=%b d=%h b=%b exp v=%b d=%h b=%b",
                         off, tx_valid, tx_data, busy, ev, ed, eb);
            end
        end
    endtask

    task automatic test_both();
        logic       ev, eb;
        logic [7:0] ed;
        do_reset();
        tx_ready = 1'b1;
        press    = 2'b11;
        for (int off = 1; off <= 24; off++) begin
            step();
            press = 2'b00;
            ev = 1'b0;
            ed = 8'h00;
            if (off >= 2 && off <= 7) begin ev = 1'b1; ed = msg_byte(1'b0, off - 2); end
            if (off >= 13 && off <= 18) begin ev = 1'b1; ed = msg_byte(1'b1, off - 13); end
            eb = (off >= 2 && off <= 11) || (off >= 13 && off <= 22);
            checks++;
            if (tx_valid !== ev || tx_data !== ed || busy !== eb || overflow !== 1'b0) begin
                errors++;
                $display("[TB] FAIL both off=%0d got v=%b d=%h b=%b o=%b exp v=%b d=%h b=%b o=0",
                         off, tx_valid, tx_data, busy, overflow, ev, ed, eb);
            end
        end
    endtask

    task automatic test_ready_toggle();
        int xfers = 0;
        do_reset();
        press    = 2'b10;
        tx_ready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc > 0) begin
                step();
                press = 2'b00;
                if (tx_valid === 1'b1) begin
                    checks++;
                    if (xfers >= 6) begin
                        errors++;
                        $display("[TB] FAIL toggle_extra cyc=%0d got valid=1 exp=0", cyc);
                    end else if (tx_data !== msg_byte(1'b1, xfers)) begin
                        errors++;
                        $display("[TB] FAIL toggle_data cyc=%0d got=%h exp=%h", cyc, tx_data, msg_byte(1'b1, xfers));
                    end
                end
            end
            tx_ready = (cyc % 4 == 0);
            if (tx_valid === 1'b1 && tx_ready) xfers++;
        end
        checks++;
        if (xfers != 6) begin errors++; $display("[TB] FAIL toggle_count got=%0d exp=6", xfers); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL toggle_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_overflow();
        logic       ev, eb, eo;
        logic [7:0] ed;
        do_reset();
        tx_ready = 1'b1;
        press    = 2'b10;
        for (int off = 1; off <= 26; off++) begin
            step();
            press = (off == 3 || off == 5) ? 2'b10 : 2'b00;
            ev = 1'b0;
            ed = 8'h00;
            if (off >= 2 && off <= 7) begin ev = 1'b1; ed = msg_byte(1'b1, off - 2); end
            if (off >= 13 && off <= 18) begin ev = 1'b1; ed = msg_byte(1'b1, off - 13); end
            eb = (off >= 2 && off <= 11) || (off >= 13 && off <= 22);
            eo = (off == 6);
            checks++;
            if (tx_valid !== ev || tx_data !== ed || busy !== eb || overflow !== eo) begin
                errors++;
                $display("[TB] FAIL overflow off=%0d got v=%b d=%h b=%b o=%b exp v=%b d=%h b=%b o=%b",
                         off, tx_valid, tx_data, busy, overflow, ev, ed, eb, eo);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       ev;
        logic [7:0] ed;
        do_reset();
        tx_ready = 1'b1;
        press    = 2'b01;
        for (int off = 1; off <= 10; off++) begin
            step();
            press = 2'b00;
            rst_n = 1'b1;
            if (off == 3) press = 2'b01;
            if (off == 5) begin rst_n = 1'b0; press = 2'b10; end
            ev = (off >= 2 && off <= 5);
            ed = ev ? msg_byte(1'b0, off - 2) : 8'h00;
            checks++;
            if (tx_valid !== ev || tx_data !== ed || busy !== ev || overflow !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid off=%0d got v=%b d=%h b=%b o=%b exp v=%b d=%h b=%b o=0",
                         off, tx_valid, tx_data, busy, overflow, ev, ed, ev);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_gap_zero();
        logic       ev, eo;
        logic [7:0] ed;
        int         p;
        do_reset();
        tx_ready = 1'b1;
        press    = 2'b01;
        for (int off = 1; off <= 22; off++) begin
            step();
            p  = (off >= 2) ? (off - 2) % 7 : 6;
            ev = (off >= 2) && (p <= 5);
            ed = ev ? msg_byte(1'b0, p) : 8'h00;
            eo = (off >= 3) && ((off - 2) % 7 != 0);
            checks++;
            if (tx_valid0 !== ev || tx_data0 !== ed || busy0 !== ev || overflow0 !== eo) begin
                errors++;
                $display("[TB] FAIL gap_zero off=%0d got v=%b d=%h b=%b o=%b exp v=%b d=%h b=%b o=%b",
                         off, tx_valid0, tx_data0, busy0, overflow0, ev, ed, ev, eo);
            end
        end
        press = 2'b00;
    endtask

    initial begin
        rst_n    = 1'b0;
        press    = 2'b00;
        tx_ready = 1'b0;
        step();
        test_reset();
        test_single();
        test_both();
        test_ready_toggle();
        test_overflow();
        test_reset_mid();
        test_gap_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_msg_tx.md
BUTTON_MSG_TX -- requirements
Module: button_msg_tx

Interface
REQ-001 The block SHALL have one parameter line: GAP_CYCLES, default 1000, idle clk cycles inserted after each message (0 to 65535).
REQ-002 The block SHALL have port: clk  input  1  system clock; all logic on the rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 The block SHALL have port: press  input  2  single-cycle press pulses from the button edge detectors; bit i is button i.
REQ-005 The block SHALL have port: tx_data  output  8  byte offered to the UART transmitter.
REQ-006 The block SHALL have port: tx_valid  output  1  tx_data is valid.
REQ-007 The block SHALL have port: tx_ready  input  1  UART accepts the byte this cycle.
REQ-008 The block SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-009 The block SHALL have port: overflow  output  1  one-cycle pulse when a press is lost.

Function
REQ-010 Message for button 0 SHALL be the 6 bytes "BTN0\r\n" = 0x42 0x54 0x4E 0x30 0x0D 0x0A; button 1 SHALL be the same with byte 3 = 0x31.
REQ-011 Each button SHALL have a pending flag, set on the clock edge after press[i]=1.
REQ-012 press[i] while pending[i] is already set and not being cleared that cycle SHALL leave pending[i] set and pulse overflow for exactly 1 cycle the next cycle.
REQ-013 press[i] in the same cycle pending[i] is cleared (message start) SHALL re-set pending[i], with no overflow.
REQ-014 Simultaneous press on both bits SHALL set both pending flags.
REQ-015 The FSM states SHALL be IDLE, SEND, GAP.
REQ-016 IDLE with any pending flag set: next edge -> SEND, selected flag cleared, byte index = 0, tx_valid = 1, tx_data = byte 0.
REQ-017 Arbitration, both pending: SHALL select the button not served last; last-served register resets to 1, so button 0 wins first.
REQ-018 Latency: a press pulse in cycle N with the FSM in IDLE and nothing pending SHALL give tx_valid=1 at cycle N+2.
REQ-019 SEND handshake: a transfer SHALL occur on any cycle with tx_valid=1 and tx_ready=1.
REQ-020 SEND: tx_data and tx_valid SHALL be held stable while tx_ready=0, for any duration.
REQ-021 After a transfer of byte k<5, tx_data SHALL be byte k+1 on the next cycle with tx_valid held high, with no bubble.
REQ-022 After transfer of byte 5: tx_valid=0 next cycle; if GAP_CYCLES>0, state SHALL go to GAP with a 16-bit counter loaded with GAP_CYCLES-1; if GAP_CYCLES=0, state SHALL go to IDLE.
REQ-023 GAP: the counter SHALL decrement each cycle, giving exactly GAP_CYCLES cycles in GAP, then IDLE; tx_valid=0 throughout.
REQ-024 Presses during SEND or GAP SHALL only update pending flags per REQ-011..013; the active message is never interrupted or altered.
REQ-025 tx_valid SHALL never depend combinationally on tx_ready, and tx_data SHALL be 0x00 whenever tx_valid=0.
REQ-026 Byte index SHALL be 3 bits and never exceed 5; bytes transferred per message SHALL be exactly 6.

Reset
REQ-027 When rst_n=0 at a rising edge, the next cycle SHALL have state=IDLE, tx_valid=0, tx_data=0x00, busy=0, overflow=0, pending=2'b00, byte index=0, gap counter=0, last-served=1.
REQ-028 Reset mid-message SHALL abort it with no further bytes; press during reset SHALL be ignored.

Verification
REQ-029 Scenario: press=01 one cycle, tx_ready=1 constant, GAP_CYCLES=4 -> tx_valid high 6 consecutive cycles from N+2, bytes 42 54 4E 30 0D 0A, then 4 cycles busy=1 with tx_valid=0, then busy=0.
REQ-030 Scenario: press=11 same cycle, tx_ready=1 -> "BTN0\r\n" then gap then "BTN1\r\n"; overflow stays 0.
REQ-031 Scenario: tx_ready toggling 1 cycle high / 3 cycles low -> every byte held stable until accepted; exactly 6 transfers, order correct.
REQ-032 Scenario: press[1] twice during a button-1 message, after it started -> one overflow pulse on the second press, one follow-up BTN1 message only.
REQ-033 Scenario: rst_n low for 1 cycle after byte 2 is accepted -> tx_valid=0 next cycle, busy=0, no further bytes, pending cleared.
REQ-034 Scenario: GAP_CYCLES=0, press[0] held pulsed every cycle -> messages back-to-back with exactly 1 IDLE cycle between them, overflow pulses as per REQ-012.
